// File: rtl/ifetch_unit_pkg.sv
// Shared constants for the instruction fetch stage.
// Also used by the next-PC logic and the testbench.
package ifetch_unit_pkg;

  localparam logic [1:0] IFU_BOOT  = 2'd0;
  localparam logic [1:0] IFU_FETCH = 2'd1;
  localparam logic [1:0] IFU_VALID = 2'd2;
  localparam logic [1:0] IFU_FAULT = 2'd3;

  localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

endpackage

// File: rtl/ifetch_unit_if.sv
// Fetch-stage bus: instruction-memory handshake plus the datapath/next-PC side.
// master = fetch unit, slave = memory/datapath environment.
interface ifetch_unit_if;

  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        imem_err;
  logic [29:0] pc;
  logic [31:0] ir;
  logic        ir_valid;
  logic        ir_ready;
  logic [29:0] npc;

  modport master (
    output imem_req, imem_addr, pc, ir, ir_valid,
    input  imem_ack, imem_rdata, imem_err, ir_ready, npc
  );

  modport slave (
    input  imem_req, imem_addr, pc, ir, ir_valid,
    output imem_ack, imem_rdata, imem_err, ir_ready, npc
  );

endinterface

// File: rtl/ifetch_unit_wait_timer.sv
// Counts FETCH cycles spent waiting for imem_ack; expired_o flags the last allowed cycle.
// TIMEOUT = 0 disables expiry.
module ifu_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [W-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr_i)     wait_cnt_d = '0;
    else if (en_i) wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  assign expired_o = (TIMEOUT != 0) && (wait_cnt_q == LAST);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: PC/IR registers, imem req/ack handshake with timeout,
// sticky fault and retired-instruction counter.
//   state | meaning
//   BOOT  | one idle cycle after reset
//   FETCH | imem_req high, waiting for ack
//   VALID | ir/pc hold an unretired instruction
//   FAULT | bus error or timeout; only reset exits
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  ifetch_unit_if.master      bus,
  output logic               fault,
  output logic [CNT_W-1:0]   instr_cnt
);

  logic [1:0]       state_q, state_d;
  logic [29:0]      pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired;

  // Counter clears outside FETCH so every FETCH entry starts from zero.
  ifu_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     ((state_q != IFU_FETCH) || bus.imem_ack),
    .en_i      (state_q == IFU_FETCH),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    case (state_q)
      IFU_BOOT: state_d = IFU_FETCH;
      IFU_FETCH: begin
        if (bus.imem_ack && bus.imem_err) begin
          fault_d = 1'b1;
          state_d = IFU_FAULT;
        end else if (bus.imem_ack) begin
          ir_d    = bus.imem_rdata;
          state_d = IFU_VALID;
        end else if (expired) begin
          fault_d = 1'b1;
          state_d = IFU_FAULT;
        end
      end
      IFU_VALID: begin
        if (bus.ir_ready) begin
          pc_d    = bus.npc;
          cnt_d   = cnt_q + 1'b1;
          state_d = IFU_FETCH;
        end
      end
      default: state_d = IFU_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IFU_BOOT;
      pc_q    <= RESET_PC[31:2];
      ir_q    <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.imem_req  = (state_q == IFU_FETCH);
  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = (state_q == IFU_VALID);
  assign fault         = fault_q;
  assign instr_cnt     = cnt_q;

endmodule
